// File: rtl/spi_work_controller_pkg.sv
// Shared opcodes, FSM encoding and status-byte layout for spi_work_controller.
// Optional checksum byte on LOAD is enabled with SPI_WORK_CSUM_EN.
package spi_work_controller_pkg;

    localparam int WORK_BYTES_DEF  = 44;
    localparam int NONCE_BYTES_DEF = 4;

    localparam logic [7:0] CMD_LOAD        = 8'h01;
    localparam logic [7:0] CMD_READ_STATUS = 8'h02;
    localparam logic [7:0] CMD_READ_NONCE  = 8'h03;
    localparam logic [7:0] CMD_ABORT       = 8'h04;

    localparam int STAT_ERR     = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_NONCE   = 2;
    localparam int STAT_OVERRUN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TX_STATUS,
        ST_TX_NONCE,
        ST_DISCARD,
        ST_ABORT
    } state_t;

    function automatic logic [7:0] pack_status(input logic err, input logic busy,
                                               input logic pending, input logic overrun);
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_ERR]     = err;
        s[STAT_BUSY]    = busy;
        s[STAT_NONCE]   = pending;
        s[STAT_OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/spi_work_controller_if.sv
// Byte-level handshake between the SPI slave shifter and the work controller.
// The master side is the SPI slave shifter; the controller uses the slave modport.
interface spi_work_controller_if;

    logic       ssel;
    logic       byte_received;
    logic [7:0] rx_byte;
    logic       data_needed;
    logic [7:0] tx_byte;

    modport master (
        output ssel,
        output byte_received,
        output rx_byte,
        output data_needed,
        input  tx_byte
    );

    modport slave (
        input  ssel,
        input  byte_received,
        input  rx_byte,
        input  data_needed,
        output tx_byte
    );

endinterface

// File: rtl/spi_work_buffer.sv
// Byte-addressed work register file; with SPI_WORK_CSUM_EN it also keeps the
// running XOR of every byte written since the last clear.
module spi_work_buffer #(
    parameter int WORK_BYTES = 44,
    parameter int IDX_W      = $clog2(WORK_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef SPI_WORK_CSUM_EN
    input  logic                    clear,
    output logic [7:0]              csum,
`endif
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [7:0]              wdata,
    output logic [WORK_BYTES*8-1:0] data
);

    // NOTE: this storage is reset on purpose -- work_data must read as zero out of reset,
    // so it stays a flop array rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (we) begin
            data[idx*8 +: 8] <= wdata;
        end
    end

`ifdef SPI_WORK_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (clear) begin
            csum <= 8'h00;
        end else if (we) begin
            csum <= csum ^ wdata;
        end
    end
`endif

endmodule

// File: rtl/spi_work_controller.sv
// Command sequencer between the SPI byte interface and the miner core.
// Define SPI_WORK_CSUM_EN to require a trailing XOR checksum byte on LOAD.
module spi_work_controller
    import spi_work_controller_pkg::*;
#(
    parameter int WORK_BYTES  = WORK_BYTES_DEF,
    parameter int NONCE_BYTES = NONCE_BYTES_DEF
) (
    input  logic                    CLK_3_33_MHZ,
    input  logic                    rst_n,
    spi_work_controller_if.slave    spi,
    output logic [WORK_BYTES*8-1:0] work_data,
    output logic                    work_valid,
    output logic                    miner_abort,
    input  logic                    miner_busy,
    input  logic                    nonce_found,
    input  logic [31:0]             nonce,
    output logic [7:0]              status
);

    localparam int CNT_W  = $clog2(WORK_BYTES + 2);
    localparam int IDX_W  = $clog2(WORK_BYTES);
    localparam int NIDX_W = $clog2(NONCE_BYTES);
    localparam logic [CNT_W-1:0] WORK_LEN   = CNT_W'(WORK_BYTES);
    localparam logic [CNT_W-1:0] NONCE_LEN  = CNT_W'(NONCE_BYTES);
    localparam logic [CNT_W-1:0] NONCE_LAST = CNT_W'(NONCE_BYTES - 1);
`ifndef SPI_WORK_CSUM_EN
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(WORK_BYTES - 1);
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       tx_q;
    logic [31:0]      nonce_q;
    logic             err;
    logic             overrun;
    logic             nonce_pending;
    logic             work_loaded;
    logic             buf_we;
    logic [7:0]       nonce_byte;
`ifdef SPI_WORK_CSUM_EN
    logic [7:0]       csum;
`endif

    assign buf_we      = (state == ST_LOAD) && !spi.ssel && spi.byte_received && (cnt < WORK_LEN);
    assign spi.tx_byte = tx_q;
    assign status      = pack_status(err, work_loaded | miner_busy, nonce_pending, overrun);

    spi_work_buffer #(
        .WORK_BYTES (WORK_BYTES),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk   (CLK_3_33_MHZ),
        .rst_n (rst_n),
`ifdef SPI_WORK_CSUM_EN
        .clear (state == ST_IDLE),
        .csum  (csum),
`endif
        .we    (buf_we),
        .idx   (cnt[IDX_W-1:0]),
        .wdata (spi.rx_byte),
        .data  (work_data)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        nonce_byte = 8'h00;
        if (cnt < NONCE_LEN) begin
            nonce_byte = nonce_q[8*cnt[NIDX_W-1:0] +: 8];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tx_q          <= 8'h00;
            nonce_q       <= 32'h0;
            err           <= 1'b0;
            overrun       <= 1'b0;
            nonce_pending <= 1'b0;
            work_loaded   <= 1'b0;
            work_valid    <= 1'b0;
            miner_abort   <= 1'b0;
        end else begin
            work_valid  <= 1'b0;
            miner_abort <= (state == ST_ABORT);

            // The nonce register is frozen while it is being shifted out.
            if (nonce_found) begin
                if (state == ST_TX_NONCE) begin
                    overrun <= 1'b1;
                end else begin
                    nonce_q       <= nonce;
                    nonce_pending <= 1'b1;
                end
            end

            if (spi.ssel) begin
                state <= ST_IDLE;
                cnt   <= '0;
                tx_q  <= 8'h00;
                if (state == ST_LOAD) begin
                    err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_q <= 8'h00;
                        if (spi.byte_received) begin
                            case (spi.rx_byte)
                                CMD_LOAD:        state <= ST_LOAD;
                                CMD_READ_STATUS: state <= ST_TX_STATUS;
                                CMD_READ_NONCE:  state <= ST_TX_NONCE;
                                CMD_ABORT:       state <= ST_ABORT;
                                default: begin
                                    err   <= 1'b1;
                                    state <= ST_DISCARD;
                                end
                            endcase
                        end
                    end

                    ST_LOAD: begin
                        tx_q <= 8'h00;
                        if (spi.byte_received) begin
                            if (cnt < WORK_LEN) begin
                                cnt <= cnt + 1'b1;
                            end
`ifdef SPI_WORK_CSUM_EN
                            if (cnt == WORK_LEN) begin
                                if (spi.rx_byte == csum) begin
                                    work_valid  <= 1'b1;
                                    work_loaded <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                                state <= ST_DISCARD;
                            end
`else
                            if (cnt == LAST_DATA) begin
                                work_valid  <= 1'b1;
                                work_loaded <= 1'b1;
                                state       <= ST_DISCARD;
                            end
`endif
                        end
                    end

                    ST_TX_STATUS: begin
                        if (spi.data_needed) begin
                            tx_q <= status;
                            if (cnt == '0) begin
                                err     <= 1'b0;
                                overrun <= 1'b0;
                                cnt     <= cnt + 1'b1;
                            end
                        end
                    end

                    ST_TX_NONCE: begin
                        if (spi.data_needed) begin
                            tx_q <= nonce_byte;
                            if (cnt < NONCE_LEN) begin
                                cnt <= cnt + 1'b1;
                                if (cnt == NONCE_LAST) begin
                                    nonce_pending <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_ABORT: begin
                        tx_q  <= 8'h00;
                        state <= ST_DISCARD;
                    end

                    default: begin
                        tx_q <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_work_controller.sv
// Self-checking bench for spi_work_controller: directed scenarios plus a randomized
// command mix compared against a flag-level model of the controller.
module tb_spi_work_controller;
    import spi_work_controller_pkg::*;

    localparam int WB = WORK_BYTES_DEF;
    localparam int NB = NONCE_BYTES_DEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_work_controller_if spi ();

    logic [WB*8-1:0] work_data;
    logic            work_valid;
    logic            miner_abort;
    logic            miner_busy;
    logic            nonce_found;
    logic [31:0]     nonce;
    logic [7:0]      status;

    spi_work_controller #(
        .WORK_BYTES  (WB),
        .NONCE_BYTES (NB)
    ) dut (
        .CLK_3_33_MHZ (clk),
        .rst_n        (rst_n),
        .spi          (spi.slave),
        .work_data    (work_data),
        .work_valid   (work_valid),
        .miner_abort  (miner_abort),
        .miner_busy   (miner_busy),
        .nonce_found  (nonce_found),
        .nonce        (nonce),
        .status       (status)
    );

    int passed   = 0;
    int total    = 0;
    int wv_count = 0;
    int ab_count = 0;
    int exp_wv   = 0;
    int exp_ab   = 0;

    // Reference model: controller-visible flags, latched nonce and last accepted work image.
    bit          m_err, m_ovr, m_pend, m_loaded;
    logic [31:0] m_nonce;
    logic [WB*8-1:0] m_work;

    always @(negedge clk) begin
        if (work_valid === 1'b1) wv_count++;
        if (miner_abort === 1'b1) ab_count++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] exp_status();
        return {4'b0000, m_ovr, m_pend, m_loaded | miner_busy, m_err};
    endfunction

    task automatic reset_dut();
        spi.ssel          = 1'b1;
        spi.byte_received = 1'b0;
        spi.rx_byte       = 8'h00;
        spi.data_needed   = 1'b0;
        miner_busy        = 1'b0;
        nonce_found       = 1'b0;
        nonce             = 32'h0;
        rst_n             = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        {m_err, m_ovr, m_pend, m_loaded} = 4'b0000;
        m_nonce = 32'h0;
        m_work  = '0;
    endtask

    task automatic start_frame();
        spi.ssel = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_frame();
        spi.ssel = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit dn);
        spi.rx_byte       = b;
        spi.byte_received = 1'b1;
        spi.data_needed   = dn;
        @(negedge clk);
        spi.byte_received = 1'b0;
        spi.data_needed   = 1'b0;
    endtask

    task automatic request_tx(output logic [7:0] t, input bit nf, input logic [31:0] nv);
        spi.data_needed = 1'b1;
        if (nf) begin
            nonce_found = 1'b1;
            nonce       = nv;
        end
        @(negedge clk);
        spi.data_needed = 1'b0;
        nonce_found     = 1'b0;
        t               = spi.tx_byte;
    endtask

    task automatic pulse_nonce(input logic [31:0] v);
        nonce       = v;
        nonce_found = 1'b1;
        @(negedge clk);
        nonce_found = 1'b0;
        m_nonce     = v;
        m_pend      = 1'b1;
    endtask

    task automatic load_frame(input int n, input bit ramp, input bit good, input int extra);
        logic [WB*8-1:0] img;
        logic [7:0]      b;
        logic [7:0]      x;
        bit              ok;
        img = m_work;
        x   = 8'h00;
        start_frame();
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            img[i*8 +: 8] = b;
            x ^= b;
            send_byte(b, 1'($urandom_range(0, 1)));
        end
        total++;
        if (spi.tx_byte !== 8'h00) $display("FAIL load_tx_zero: tx_byte=%h expected 00", spi.tx_byte);
        else passed++;
        ok = (n == WB);
        // Without the checksum option this trailing byte must simply be ignored.
        if (ok) send_byte(good ? x : ~x, 1'b0);
`ifdef SPI_WORK_CSUM_EN
        ok = ok && good;
`endif
        for (int i = 0; i < extra; i++) send_byte(8'($urandom), 1'b0);
        end_frame();
        if (ok) begin
            m_work   = img;
            m_loaded = 1'b1;
            exp_wv++;
        end else begin
            m_err = 1'b1;
        end
        total++;
        if (wv_count !== exp_wv) $display("FAIL load_work_valid: pulses=%0d expected %0d", wv_count, exp_wv);
        else passed++;
        if (ok) begin
            total++;
            if (work_data !== m_work) $display("FAIL load_work_data: got %h expected %h", work_data, m_work);
            else passed++;
        end
    endtask

    task automatic read_status_frame(input int k);
        logic [7:0] t, e;
        start_frame();
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < k; i++) begin
            request_tx(t, 1'b0, 32'h0);
            e = exp_status();
            if (i == 0) begin
                m_err = 1'b0;
                m_ovr = 1'b0;
            end
            total++;
            if (t !== e) $display("FAIL status_byte[%0d]: tx=%h expected %h", i, t, e);
            else passed++;
        end
        end_frame();
    endtask

    task automatic read_nonce_frame(input int k, input int nf_at, input logic [31:0] nv);
        logic [7:0] t, e;
        start_frame();
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < k; i++) begin
            request_tx(t, i == nf_at, nv);
            e = (i < NB) ? m_nonce[8*i +: 8] : 8'h00;
            if (i == NB - 1) m_pend = 1'b0;
            if (i == nf_at) m_ovr = 1'b1;
            total++;
            if (t !== e) $display("FAIL nonce_byte[%0d]: tx=%h expected %h", i, t, e);
            else passed++;
        end
        end_frame();
    endtask

    task automatic test_reset();
        reset_dut();
        total += 5;
        if (spi.tx_byte !== 8'h00) $display("FAIL reset_tx: got %h expected 00", spi.tx_byte); else passed++;
        if (work_data !== '0) $display("FAIL reset_work_data: got %h expected 0", work_data); else passed++;
        if (work_valid !== 1'b0) $display("FAIL reset_work_valid: got %b expected 0", work_valid); else passed++;
        if (miner_abort !== 1'b0) $display("FAIL reset_abort: got %b expected 0", miner_abort); else passed++;
        if (status !== 8'h00) $display("FAIL reset_status: got %h expected 00", status); else passed++;
    endtask

    task automatic test_partial_load();
        reset_dut();
        load_frame(10, 1'b0, 1'b1, 0);
        total++;
        if (status !== 8'h01) $display("FAIL partial_status: got %h expected 01", status); else passed++;
        read_status_frame(1);
        read_status_frame(1);
    endtask

    task automatic test_load();
        reset_dut();
        load_frame(WB, 1'b1, 1'b1, 2);
        total += 3;
        if (work_data[7:0] !== 8'h00) $display("FAIL load_byte0: got %h expected 00", work_data[7:0]); else passed++;
        if (work_data[351:344] !== 8'h2B) $display("FAIL load_byte43: got %h expected 2b", work_data[351:344]); else passed++;
        if (status[1] !== 1'b1) $display("FAIL load_status_bit1: got %b expected 1", status[1]); else passed++;
`ifdef SPI_WORK_CSUM_EN
        load_frame(WB, 1'b0, 1'b0, 0);
        total++;
        if (status !== 8'h03) $display("FAIL csum_bad_status: got %h expected 03", status); else passed++;
`endif
    endtask

    task automatic test_nonce();
        logic [31:0] v;
        reset_dut();
        pulse_nonce(32'hDEADBEEF);
        total++;
        if (status !== 8'h04) $display("FAIL nonce_pending_set: status=%h expected 04", status); else passed++;
        read_nonce_frame(NB + 2, -1, 32'h0);
        total++;
        if (status !== 8'h00) $display("FAIL nonce_pending_clr: status=%h expected 00", status); else passed++;
        // A second find while byte 2 is being shifted out must not disturb the readout.
        pulse_nonce(32'hDEADBEEF);
        read_nonce_frame(NB, 1, $urandom);
        total++;
        if (status !== 8'h08) $display("FAIL nonce_overrun: status=%h expected 08", status); else passed++;
        read_status_frame(2);
        v = $urandom;
        pulse_nonce(v);
        read_nonce_frame(NB, NB - 1, ~v);
        total++;
        if (status !== exp_status()) $display("FAIL nonce_complete_overrun: status=%h expected %h", status, exp_status()); else passed++;
        read_nonce_frame(NB, -1, 32'h0);
    endtask

    task automatic test_abort();
        reset_dut();
        start_frame();
        send_byte(8'h04, 1'b0);
        total += 3;
        if (miner_abort !== 1'b0) $display("FAIL abort_early: got %b expected 0", miner_abort); else passed++;
        @(negedge clk);
        if (miner_abort !== 1'b1) $display("FAIL abort_pulse: got %b expected 1", miner_abort); else passed++;
        @(negedge clk);
        if (miner_abort !== 1'b0) $display("FAIL abort_width: got %b expected 0", miner_abort); else passed++;
        end_frame();
        exp_ab++;
        start_frame();
        send_byte(8'h7F, 1'b0);
        send_byte(8'h01, 1'b0);
        end_frame();
        m_err = 1'b1;
        total += 3;
        if (status !== 8'h01) $display("FAIL bad_opcode_err: status=%h expected 01", status); else passed++;
        if (ab_count !== exp_ab) $display("FAIL abort_count: got %0d expected %0d", ab_count, exp_ab); else passed++;
        if (wv_count !== exp_wv) $display("FAIL bad_opcode_wv: got %0d expected %0d", wv_count, exp_wv); else passed++;
    endtask

    task automatic test_async_reset();
        reset_dut();
        pulse_nonce($urandom);
        start_frame();
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom) | 8'h01, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (work_data !== '0) $display("FAIL async_work_data: got %h expected 0", work_data); else passed++;
        if (status !== 8'h00) $display("FAIL async_status: got %h expected 00", status); else passed++;
        if (spi.tx_byte !== 8'h00) $display("FAIL async_tx: got %h expected 00", spi.tx_byte); else passed++;
        if ({work_valid, miner_abort} !== 2'b00) $display("FAIL async_strobes: got %b expected 00", {work_valid, miner_abort}); else passed++;
        @(negedge clk);
        reset_dut();
    endtask

    task automatic test_random();
        int op;
        int k;
        for (int it = 0; it < 24; it++) begin
            miner_busy = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 5);
            case (op)
                0: load_frame(WB, 1'b0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
                1: load_frame($urandom_range(1, WB - 1), 1'b0, 1'b1, 0);
                2: pulse_nonce($urandom);
                3: begin
                    k = $urandom_range(1, NB + 2);
                    read_nonce_frame(k, $urandom_range(0, k + 1) - 1, $urandom);
                end
                4: read_status_frame($urandom_range(1, 3));
                default: begin
                    start_frame();
                    send_byte(8'($urandom_range(5, 255)), 1'b0);
                    end_frame();
                    m_err = 1'b1;
                end
            endcase
            total += 2;
            if (status !== exp_status()) $display("FAIL rand_status[%0d]: got %h expected %h", it, status, exp_status());
            else passed++;
            if (ab_count !== exp_ab) $display("FAIL rand_abort[%0d]: got %0d expected %0d", it, ab_count, exp_ab);
            else passed++;
        end
        miner_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_partial_load();
        test_load();
        test_nonce();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
